beat_seq_ctrl: RTL and testbench

- Parametrised machine-cycle sequencer for the hardwired controller.
- Generates the beat timing internally as a one-hot W vector. The previous generation took W1/W2/W3 as external inputs.
- Latches the console mode from the raw switches and tracks a multi-cycle setup phase, generalising the single STO/SSTO flags to an N-step PHASE counter.
- Counts console transfers and ends a console run after a programmable length. The decode/strobe logic consumes W, SWA/SWB/SWC and STO from this block.

---
 rtl/beat_seq_ctrl.sv | 174 +++++++++++++++++
 tb/tb_beat_seq_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/beat_seq_ctrl.sv
// beat_seq_ctrl: machine-cycle sequencer for the hardwired controller.
// Generates the one-hot beat vector W internally, latches the console mode
// from the raw switches, counts setup cycles (PHASE/STO) and console
// transfers, and ends a console run after XFER_LEN transfers.
// All state updates happen on the falling edge of T3; CLR is an
// asynchronous active-low reset.
// Optional feature macro: BEAT_STEP_EN. It adds the STEP input for
// single-beat stepping with START.
module beat_seq_ctrl #(
  parameter int NBEATS = 3,   // beats per machine cycle, 2..8
  parameter int NPHASE = 2,   // setup cycles before STO, 1..7
  parameter int CNT_W  = 8    // transfer length / counter width
) (
  input  logic              T3,
  input  logic              CLR,
  input  logic              START,
`ifdef BEAT_STEP_EN
  input  logic              STEP,
`endif
  input  logic              RSWA,
  input  logic              RSWB,
  input  logic              RSWC,
  input  logic              SHORT,
  input  logic              LONG,
  input  logic              STOP,
  input  logic [CNT_W-1:0]  XFER_LEN,
  output logic [NBEATS-1:0] W,
  output logic              SWA,
  output logic              SWB,
  output logic              SWC,
  output logic [2:0]        PHASE,
  output logic              STO,
  output logic              RUN,
  output logic              DONE,
  output logic [CNT_W-1:0]  XFER_CNT
);

  localparam logic [2:0]        PHASE_MAX = 3'(NPHASE);
  localparam logic [NBEATS-1:0] BEAT0     = {{(NBEATS-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t            state, state_nxt;
  logic [NBEATS-1:0] w_q, w_nxt;
  logic [2:0]        mode_q, mode_nxt;
  logic [2:0]        phase_q, phase_nxt;
  logic              done_q, done_nxt;
  logic [CNT_W-1:0]  cnt_q, cnt_nxt;

  logic [2:0]        raw_mode;
  logic              advance;
  logic              cycle_end;
  logic              console;
  logic              len_hit;
  logic [CNT_W-1:0]  cnt_inc;

  assign raw_mode = {RSWC, RSWB, RSWA};

  // A beat transition happens on every edge while running, unless stepping
  // is enabled, in which case only edges with START held high advance.
`ifdef BEAT_STEP_EN
  assign advance = (state == S_RUN) && (!STEP || START);
`else
  assign advance = (state == S_RUN);
`endif

  // SHORT ends at beat 0 before LONG is considered; on the last beat the
  // cycle always ends, so LONG has no effect when NBEATS is 2.
  assign cycle_end = (w_q[0] && SHORT) || (w_q[1] && !LONG) || w_q[NBEATS-1];

  // Console modes are exactly one switch set; 000 is program execution.
  assign console = (mode_q == 3'b001) || (mode_q == 3'b010) || (mode_q == 3'b100);
  assign cnt_inc = cnt_q + CNT_ONE;

  // Next-state and datapath decode for the idle/run controller.
  always_comb begin
    // NOTE: every variable gets its hold value first so that no path through
    // the case/if tree leaves it unassigned, which would infer a latch.
    state_nxt = state;
    w_nxt     = w_q;
    mode_nxt  = mode_q;
    phase_nxt = phase_q;
    done_nxt  = done_q;
    cnt_nxt   = cnt_q;
    len_hit   = 1'b0;

    case (state)
      S_IDLE: begin
        if (START) begin
          state_nxt = S_RUN;
          w_nxt     = BEAT0;
          done_nxt  = 1'b0;
          mode_nxt  = raw_mode;
          // A new mode restarts setup and transfer counting; the same mode
          // resumes where the previous run left off.
          if (raw_mode != mode_q) begin
            phase_nxt = 3'd0;
            cnt_nxt   = '0;
          end
        end
      end

      S_RUN: begin
        if (advance) begin
          if (!cycle_end) begin
            w_nxt = w_q << 1;
          end else begin
            // Bookkeeping for the completed cycle: setup first, then
            // transfer counting once setup is complete.
            if (phase_q < PHASE_MAX) begin
              phase_nxt = phase_q + 3'd1;
            end else if (console) begin
              cnt_nxt = cnt_inc;
              len_hit = (XFER_LEN != '0) && (cnt_inc == XFER_LEN);
            end
            // Termination: a reached transfer length wins over STOP, and
            // STOP halts any cycle, including setup cycles.
            if (len_hit) begin
              done_nxt  = 1'b1;
              state_nxt = S_IDLE;
              w_nxt     = '0;
            end else if (STOP) begin
              state_nxt = S_IDLE;
              w_nxt     = '0;
            end else begin
              w_nxt = BEAT0;
            end
          end
        end
      end

      default: begin
        state_nxt = S_IDLE;
        w_nxt     = '0;
      end
    endcase
  end

  // State register, updated on falling T3 and cleared asynchronously by CLR.
  always_ff @(negedge T3 or negedge CLR) begin
    if (!CLR) begin
      state   <= S_IDLE;
      w_q     <= '0;
      mode_q  <= 3'b000;
      phase_q <= 3'd0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values computed above, independent of statement order.
      state   <= state_nxt;
      w_q     <= w_nxt;
      mode_q  <= mode_nxt;
      phase_q <= phase_nxt;
      done_q  <= done_nxt;
      cnt_q   <= cnt_nxt;
    end
  end

  assign W        = w_q;
  assign SWA      = mode_q[0];
  assign SWB      = mode_q[1];
  assign SWC      = mode_q[2];
  assign PHASE    = phase_q;
  assign STO      = (phase_q == PHASE_MAX);
  assign RUN      = (state == S_RUN);
  assign DONE     = done_q;
  assign XFER_CNT = cnt_q;

endmodule

// File: tb/tb_beat_seq_ctrl.sv
// Directed testbench for beat_seq_ctrl with default parameters
// (NBEATS=3, NPHASE=2, CNT_W=8). Outputs are sampled 1 ns after each
// falling T3 edge; inputs are changed at the same point.
`timescale 1ns/1ps
module tb_beat_seq_ctrl;

  logic       T3 = 1'b1;
  logic       CLR;
  logic       START;
  logic       STEP;
  logic       RSWA, RSWB, RSWC;
  logic       SHORT, LONG, STOP;
  logic [7:0] XFER_LEN;
  logic [2:0] W;
  logic       SWA, SWB, SWC;
  logic [2:0] PHASE;
  logic       STO, RUN, DONE;
  logic [7:0] XFER_CNT;

  int checks = 0;
  int errors = 0;

  beat_seq_ctrl #(.NBEATS(3), .NPHASE(2), .CNT_W(8)) dut (
    .T3(T3), .CLR(CLR), .START(START),
`ifdef BEAT_STEP_EN
    .STEP(STEP),
`endif
    .RSWA(RSWA), .RSWB(RSWB), .RSWC(RSWC),
    .SHORT(SHORT), .LONG(LONG), .STOP(STOP), .XFER_LEN(XFER_LEN),
    .W(W), .SWA(SWA), .SWB(SWB), .SWC(SWC), .PHASE(PHASE), .STO(STO),
    .RUN(RUN), .DONE(DONE), .XFER_CNT(XFER_CNT)
  );

  always #5 T3 = ~T3;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to 1 ns after the next active (falling) edge.
  task automatic tick();
    @(negedge T3);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".W"}, W, 3'b000);
    check({tag, ".RUN"}, RUN, 1'b0);
    check({tag, ".SW"}, {SWC, SWB, SWA}, 3'b000);
    check({tag, ".PHASE"}, PHASE, 3'd0);
    check({tag, ".STO"}, STO, 1'b0);
    check({tag, ".DONE"}, DONE, 1'b0);
    check({tag, ".XFER_CNT"}, XFER_CNT, 8'd0);
  endtask

  // Expected values for the console STOP-each-cycle test.
  logic [2:0] stop_phase [4] = '{3'd1, 3'd2, 3'd2, 3'd2};
  logic [7:0] stop_cnt   [4] = '{8'd0, 8'd0, 8'd1, 8'd2};
  logic [7:0] xfer_phase [5] = '{8'd1, 8'd2, 8'd2, 8'd2, 8'd2};
  logic [7:0] xfer_cnt_e [5] = '{8'd0, 8'd0, 8'd1, 8'd2, 8'd3};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    CLR = 1'b0; START = 1'b0; STEP = 1'b0;
    RSWA = 1'b0; RSWB = 1'b0; RSWC = 1'b0;
    SHORT = 1'b0; LONG = 1'b0; STOP = 1'b0; XFER_LEN = 8'd0;
    #12;
    check_all_zero("reset");
    CLR = 1'b1;

    // Mode 000, free-running two-beat cycles.
    START = 1'b1;
    tick();
    START = 1'b0;
    check("m0.start.RUN", RUN, 1'b1);
    check("m0.start.W", W, 3'b001);
    check("m0.start.PHASE", PHASE, 3'd0);
    tick(); check("m0.c1b1.W", W, 3'b010);
    tick(); check("m0.c2b0.W", W, 3'b001);
    check("m0.c2.PHASE", PHASE, 3'd1);
    check("m0.c2.STO", STO, 1'b0);
    tick(); check("m0.c2b1.W", W, 3'b010);
    tick(); check("m0.c3b0.W", W, 3'b001);
    check("m0.c3.PHASE", PHASE, 3'd2);
    check("m0.c3.STO", STO, 1'b1);
    tick(); tick();
    check("m0.c4.PHASE", PHASE, 3'd2);
    check("m0.c4.XFER_CNT", XFER_CNT, 8'd0);
    check("m0.c4.DONE", DONE, 1'b0);

    // LONG extends the cycle to beat 2.
    LONG = 1'b1;
    tick(); check("long.b1", W, 3'b010);
    tick(); check("long.b2", W, 3'b100);
    tick(); check("long.wrap", W, 3'b001);
    // SHORT has priority over LONG at beat 0.
    SHORT = 1'b1;
    tick(); check("short.W", W, 3'b001);
    check("short.RUN", RUN, 1'b1);
    SHORT = 1'b0; LONG = 1'b0; STOP = 1'b1;
    tick(); check("stop0.b1", W, 3'b010);
    tick(); check("stop0.W", W, 3'b000);
    check("stop0.RUN", RUN, 1'b0);
    STOP = 1'b0;

    // Mode 010 with XFER_LEN=3: two setup cycles, then three transfers.
    RSWB = 1'b1; XFER_LEN = 8'd3; START = 1'b1;
    tick();
    START = 1'b0;
    check("x.start.SW", {SWC, SWB, SWA}, 3'b010);
    check("x.start.PHASE", PHASE, 3'd0);
    check("x.start.RUN", RUN, 1'b1);
    RSWA = 1'b1; RSWB = 1'b0; RSWC = 1'b1;   // ignored while running
    for (int c = 0; c < 5; c++) begin
      tick(); tick();
      check($sformatf("x.c%0d.PHASE", c + 1), PHASE, xfer_phase[c]);
      check($sformatf("x.c%0d.XFER_CNT", c + 1), XFER_CNT, xfer_cnt_e[c]);
      check($sformatf("x.c%0d.DONE", c + 1), DONE, (c == 4));
      check($sformatf("x.c%0d.RUN", c + 1), RUN, (c != 4));
    end
    check("x.end.W", W, 3'b000);
    check("x.hold.SW", {SWC, SWB, SWA}, 3'b010);
    tick();
    check("x.idle.RUN", RUN, 1'b0);
    check("x.idle.DONE", DONE, 1'b1);

    // Mode 001, STOP each cycle, four START presses.
    RSWA = 1'b1; RSWB = 1'b0; RSWC = 1'b0; XFER_LEN = 8'd0; STOP = 1'b1;
    for (int p = 0; p < 4; p++) begin
      START = 1'b1;
      tick();
      START = 1'b0;
      check($sformatf("s.p%0d.RUN", p), RUN, 1'b1);
      check($sformatf("s.p%0d.DONE", p), DONE, 1'b0);
      tick(); tick();
      check($sformatf("s.p%0d.RUNend", p), RUN, 1'b0);
      check($sformatf("s.p%0d.PHASE", p), PHASE, stop_phase[p]);
      check($sformatf("s.p%0d.XFER_CNT", p), XFER_CNT, stop_cnt[p]);
      check($sformatf("s.p%0d.SW", p), {SWC, SWB, SWA}, 3'b001);
    end
    STOP = 1'b0;
    RSWA = 1'b0; RSWC = 1'b1; START = 1'b1;
    tick();
    START = 1'b0;
    check("sw100.SW", {SWC, SWB, SWA}, 3'b100);
    check("sw100.PHASE", PHASE, 3'd0);
    check("sw100.XFER_CNT", XFER_CNT, 8'd0);

    // Asynchronous reset in the middle of a cycle.
    tick();
    check("clr.pre.W", W, 3'b010);
    CLR = 1'b0;
    #1;
    check_all_zero("clr");
    #1 CLR = 1'b1;
    RSWC = 1'b0;

`ifdef BEAT_STEP_EN
    // Stepping: W moves only on edges with START high.
    STEP = 1'b1; START = 1'b1;
    tick();
    START = 1'b0;
    check("step.start.W", W, 3'b001);
    for (int e = 0; e < 5; e++) begin
      tick();
      check($sformatf("step.hold%0d.W", e), W, 3'b001);
    end
    START = 1'b1;
    tick();
    START = 1'b0;
    check("step.adv.W", W, 3'b010);
    STEP = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
